// File: rtl/rr_arbiter8.sv
// 8-way round-robin arbiter with per-owner hold limit and a saturating grant counter.
// Latency: grant is registered, visible one cycle after the request edge; no idle bubble on handover.
// Backpressure: none; en low releases the current owner and blocks new grants.
module rr_arbiter8 #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic [7:0] grant_cnt
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state, state_n;
    logic [2:0] owner, owner_n;
    logic [2:0] ptr, ptr_n;
    logic [7:0] hold_cnt, hold_n;
    logic       start;

    logic       keep, rel;
    logic [2:0] search_base;
    logic [2:0] cand;
    logic [2:0] win_idx;
    logic       win_found;

    always_comb begin
        keep        = (state == GRANT) && en && req[owner] && (hold_cnt < HOLD_LAST);
        rel         = (state == GRANT) && !keep;
        // On release the search already starts past the outgoing owner.
        search_base = rel ? owner + 3'd1 : ptr;
    end

    // Walk offsets from the far end so the nearest requester wins last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = search_base;
        cand      = search_base;
        for (int i = 7; i >= 0; i--) begin
            cand = search_base + 3'(i);
            if (req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_n = state;
        owner_n = owner;
        ptr_n   = ptr;
        hold_n  = hold_cnt;
        start   = 1'b0;
        case (state)
            IDLE: begin
                if (en && win_found) begin
                    state_n = GRANT;
                    owner_n = win_idx;
                    hold_n  = 8'd0;
                    start   = 1'b1;
                end
            end
            GRANT: begin
                if (keep) begin
                    hold_n = hold_cnt + 8'd1;
                end else begin
                    ptr_n = owner + 3'd1;
                    if (en && win_found) begin
                        owner_n = win_idx;
                        hold_n  = 8'd0;
                        start   = 1'b1;
                    end else begin
                        state_n = IDLE;
                        hold_n  = 8'd0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            owner     <= 3'd0;
            ptr       <= 3'd0;
            hold_cnt  <= 8'd0;
            gnt       <= 8'd0;
            gnt_idx   <= 3'd0;
            gnt_valid <= 1'b0;
            grant_cnt <= 8'd0;
        end else begin
            state     <= state_n;
            owner     <= owner_n;
            ptr       <= ptr_n;
            hold_cnt  <= hold_n;
            gnt       <= (state_n == GRANT) ? (8'd1 << owner_n) : 8'd0;
            gnt_valid <= (state_n == GRANT);
            if (state_n == GRANT) begin
                gnt_idx <= owner_n;
            end
            if (start && (grant_cnt != 8'hFF)) begin
                grant_cnt <= grant_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
module tb_rr_arbiter8;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] req;

    logic [7:0] gnt8, gnt1;
    logic [2:0] idx8, idx1;
    logic       vld8, vld1;
    logic [7:0] cnt8, cnt1;

    always #5 clk = ~clk;

    rr_arbiter8 #(.MAX_HOLD(8)) dut8 (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .gnt(gnt8), .gnt_idx(idx8), .gnt_valid(vld8), .grant_cnt(cnt8)
    );

    rr_arbiter8 #(.MAX_HOLD(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .gnt(gnt1), .gnt_idx(idx1), .gnt_valid(vld1), .grant_cnt(cnt1)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       en;
        logic [7:0] req;
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       vld;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs just after an edge, then sample just after the next edge.
    task automatic step(input logic e, input logic [7:0] r);
        en  = e;
        req = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_idx;
        int exp_cnt;
        logic [7:0] exp_gnt;

        //          en    req     gnt     idx   vld   cnt
        tbl[0]  = '{1'b1, 8'h90, 8'h10, 3'd4, 1'b1, 8'd1};
        tbl[1]  = '{1'b1, 8'h90, 8'h10, 3'd4, 1'b1, 8'd1};
        tbl[2]  = '{1'b1, 8'h80, 8'h80, 3'd7, 1'b1, 8'd2};
        tbl[3]  = '{1'b1, 8'h81, 8'h80, 3'd7, 1'b1, 8'd2};
        tbl[4]  = '{1'b1, 8'h05, 8'h01, 3'd0, 1'b1, 8'd3};
        tbl[5]  = '{1'b1, 8'h04, 8'h04, 3'd2, 1'b1, 8'd4};
        tbl[6]  = '{1'b0, 8'h04, 8'h00, 3'd2, 1'b0, 8'd4};
        tbl[7]  = '{1'b0, 8'hFF, 8'h00, 3'd2, 1'b0, 8'd4};
        tbl[8]  = '{1'b1, 8'h04, 8'h04, 3'd2, 1'b1, 8'd5};
        tbl[9]  = '{1'b1, 8'h00, 8'h00, 3'd2, 1'b0, 8'd5};
        tbl[10] = '{1'b1, 8'h00, 8'h00, 3'd2, 1'b0, 8'd5};
        tbl[11] = '{1'b1, 8'h09, 8'h08, 3'd3, 1'b1, 8'd6};

        rst = 1'b0;
        en  = 1'b0;
        req = 8'h00;
        #2;
        chk("reset_gnt", gnt8, 8'h00);
        chk("reset_idx", idx8, 3'd0);
        chk("reset_vld", vld8, 1'b0);
        chk("reset_cnt", cnt8, 8'd0);
        chk("reset_gnt_mh1", gnt1, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b1;

        for (int v = 0; v < 12; v++) begin
            step(tbl[v].en, tbl[v].req);
            chk($sformatf("vec%0d_gnt", v), gnt8, tbl[v].gnt);
            chk($sformatf("vec%0d_idx", v), idx8, tbl[v].idx);
            chk($sformatf("vec%0d_vld", v), vld8, tbl[v].vld);
            chk($sformatf("vec%0d_cnt", v), cnt8, tbl[v].cnt);
        end

        // Single requester held: regranted every MAX_HOLD cycles without a gap.
        rst = 1'b0;
        #1;
        rst = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            step(1'b1, 8'h01);
            chk($sformatf("hold%0d_gnt", k), gnt8, 8'h01);
            chk($sformatf("hold%0d_cnt", k), cnt8, ((k - 1) / 8) + 1);
        end

        // Asynchronous reset between edges while a grant is active.
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_gnt", gnt8, 8'h00);
        chk("async_rst_vld", vld8, 1'b0);
        chk("async_rst_cnt", cnt8, 8'd0);
        chk("async_rst_idx", idx8, 3'd0);
        #1;
        rst = 1'b1;
        #1;
        step(1'b1, 8'h06);
        chk("post_rst_gnt", gnt8, 8'h02);
        chk("post_rst_idx", idx8, 3'd1);
        chk("post_rst_cnt", cnt8, 8'd1);

        // MAX_HOLD=1 with all requesting: strict rotation, counter saturates.
        #2;
        rst = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        for (int k = 1; k <= 300; k++) begin
            step(1'b1, 8'hFF);
            exp_idx = (k - 1) % 8;
            exp_cnt = (k > 255) ? 255 : k;
            exp_gnt = 8'd1 << exp_idx;
            chk($sformatf("rot%0d_idx", k), idx1, exp_idx);
            chk($sformatf("rot%0d_gnt", k), gnt1, exp_gnt);
            chk($sformatf("rot%0d_cnt", k), cnt1, exp_cnt);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_arbiter8.md
RR_ARBITER8 -- requirements
Module: rr_arbiter8

Interface
REQ-001 Parameter: MAX_HOLD, 8, maximum consecutive cycles one requester SHALL hold a grant; legal range 1..255.
REQ-002 Port: clk  input  1  single clock; all state SHALL change on rising edge only.
REQ-003 Port: rst  input  1  reset, asynchronous, active-low.
REQ-004 Port: en  input  1  arbitration enable; low SHALL force release and block new grants.
REQ-005 Port: req  input  8  request vector, req[i] high = requester i wants the shared resource.
REQ-006 Port: gnt  output  8  one-hot grant vector, registered.
REQ-007 Port: gnt_idx  output  3  binary index of granted requester, registered; drives the downstream 7-seg display path.
REQ-008 Port: gnt_valid  output  1  high exactly when gnt is non-zero, registered.
REQ-009 Port: grant_cnt  output  8  count of grants issued since reset, saturating at 255.

Function
REQ-010 The block SHALL hold a state register with two states, IDLE and GRANT, plus owner[2:0], ptr[2:0] (round-robin start) and hold_cnt[7:0].
REQ-011 gnt SHALL be zero or one-hot; gnt_valid SHALL equal |gnt; gnt_idx SHALL equal owner while gnt_valid is high and hold its last value otherwise.
REQ-012 Arbitration SHALL select the first i with req[i]=1, searching ptr, ptr+1, ... ptr+7 modulo 8.
REQ-013 IDLE: if en=1 and req!=0 at a rising edge, the block SHALL enter GRANT at that edge with owner = arbitration winner, hold_cnt=0; gnt visible the following cycle (1-cycle latency from req).
REQ-014 IDLE with en=0 or req=0 SHALL remain IDLE with gnt=0.
REQ-015 GRANT: the grant SHALL be kept while en=1, req[owner]=1 and hold_cnt < MAX_HOLD-1; hold_cnt SHALL increment by 1 each held cycle.
REQ-016 Release SHALL occur at the edge where en=0, or req[owner]=0, or hold_cnt = MAX_HOLD-1 with req[owner]=1.
REQ-017 On release ptr SHALL become owner+1 modulo 8 (wrap 7 -> 0).
REQ-018 On release with en=1 and req!=0, the block SHALL grant the new winner (searched from the updated ptr) at the same edge, with no idle bubble; hold_cnt SHALL restart at 0.
REQ-019 On timeout with only req[owner] asserted, the same owner SHALL be regranted (search reaches it last); this counts as a new grant.
REQ-020 On release with en=0 or req=0, the block SHALL enter IDLE and drive gnt=0 the next cycle.
REQ-021 grant_cnt SHALL increment by 1 at every edge that starts a grant (REQ-013, REQ-018, REQ-019) and SHALL stay at 255 once reached.
REQ-022 Changes of req[j], j!=owner, during GRANT SHALL not affect gnt until release.
REQ-023 MAX_HOLD=1 SHALL yield a new arbitration every cycle (pure round-robin rotation among active requesters).

Reset
REQ-024 With rst=0, asynchronously and regardless of clk: state=IDLE, gnt=0, gnt_idx=0, gnt_valid=0, owner=0, ptr=0, hold_cnt=0, grant_cnt=0.
REQ-025 Reset asserted mid-grant SHALL drop gnt immediately; the first edge after rst deasserts SHALL arbitrate from ptr=0.

Verification
REQ-026 Reset, en=1, req=8'h90 -> after 1 edge gnt=8'h10, gnt_idx=4, gnt_valid=1, grant_cnt=1.
REQ-027 MAX_HOLD=8, req=8'h01 held constant -> gnt=8'h01 for 8 cycles, regranted to requester 0, grant_cnt increments every 8 cycles, no gap.
REQ-028 req=8'h81, owner=7, req[7] drops -> next cycle gnt=8'h01 (wrap 7->0), ptr=0 after release.
REQ-029 req=8'hFF, MAX_HOLD=1 -> gnt_idx sequence 0,1,2,...,7,0 one per cycle; grant_cnt saturates at 255 after 255 grants.
REQ-030 Grant active, en driven low -> next cycle gnt=0, gnt_valid=0, gnt_idx holds last owner; en high again with req=8'h04 -> gnt=8'h04 one cycle later.
REQ-031 rst pulsed low mid-grant between clock edges -> gnt=0, grant_cnt=0 immediately; after release with req=8'h06 -> gnt=8'h02.
